// File: rtl/logic_unit_pipe.sv
// Single-stage bitwise logic unit with valid/ready handshakes on both sides.
// Op 111 folds a multi-beat XOR-accumulate sequence into one result on the last beat.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             par
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] r_y;
  logic             r_out_valid;
  logic             r_zero;
  logic             r_par;
  logic             w_accept;
  logic             w_is_acc;
  logic             w_produce;

  // Ready is suppressed during reset so a beat presented then is never taken.
  assign in_ready  = rst_n & (~r_out_valid | out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_is_acc  = (op == 3'b111);
  assign w_produce = w_accept & (~w_is_acc | last);

  always_comb begin
    w_res = '0;
    unique case (op)
      3'b000: w_res = a & b;
      3'b001: w_res = a | b;
      3'b010: w_res = ~(a & b);
      3'b011: w_res = ~(a | b);
      3'b100: w_res = a ^ b;
      3'b101: w_res = ~(a ^ b);
      3'b110: w_res = ~a;
      3'b111: w_res = (r_state == ACCUM) ? (r_acc ^ a) : a;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    if (w_accept) begin
      if (w_is_acc && !last) begin
        w_acc_nxt   = (r_state == ACCUM) ? (r_acc ^ a) : a;
        w_state_nxt = ACCUM;
      end else begin
        // Closing an accumulation or any plain op discards the partial acc.
        w_acc_nxt   = '0;
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_zero      <= 1'b1;
      r_par       <= 1'b0;
    end else if (w_produce) begin
      r_out_valid <= 1'b1;
      r_y         <= w_res;
      r_zero      <= ~|w_res;
      r_par       <= ^w_res;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign zero      = r_zero;
  assign par       = r_par;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=8): bitwise ops, accumulate, backpressure,
// abort, reset mid-accumulate and a 16-beat full-throughput run.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero;
  logic       par;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] exp_y;
  logic [2:0] r_op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .par       (par)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat for a single edge, then drop in_valid; outputs are sampled 1 time unit later.
  task automatic send(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                      input logic l);
    op       = o;
    a        = va;
    b        = vb;
    last     = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ey, input logic ez, input logic ep);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_y"},     64'(y),         64'(ey));
    chk({tag, "_zero"},  64'(zero),      64'(ez));
    chk({tag, "_par"},   64'(par),       64'(ep));
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] va,
                                        input logic [7:0] vb);
    case (o)
      3'd0: return va & vb;
      3'd1: return va | vb;
      3'd2: return 8'hFF ^ (va & vb);
      3'd3: return 8'hFF ^ (va | vb);
      3'd4: return va ^ vb;
      3'd5: return 8'hFF ^ va ^ vb;
      default: return 8'hFF ^ va;
    endcase
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 3'd0;
    a         = 8'h00;
    b         = 8'h00;
    last      = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(y), 64'h00);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_par", 64'(par), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Bitwise ops on a=F0 b=3C
    send(3'b000, 8'hF0, 8'h3C, 1'b0); chk_out("and",  8'h30, 1'b0, 1'b0);
    send(3'b001, 8'hF0, 8'h3C, 1'b0); chk_out("or",   8'hFC, 1'b0, 1'b0);
    send(3'b010, 8'hF0, 8'h3C, 1'b0); chk_out("nand", 8'hCF, 1'b0, 1'b0);
    send(3'b011, 8'hF0, 8'h3C, 1'b0); chk_out("nor",  8'h03, 1'b0, 1'b0);
    send(3'b100, 8'hF0, 8'h3C, 1'b0); chk_out("xor",  8'hCC, 1'b0, 1'b0);
    send(3'b101, 8'hF0, 8'h3C, 1'b0); chk_out("xnor", 8'h33, 1'b0, 1'b0);
    send(3'b110, 8'hF0, 8'h3C, 1'b1); chk_out("not",  8'h0F, 1'b0, 1'b0);
    send(3'b000, 8'h0F, 8'hF0, 1'b0); chk_out("and_zero", 8'h00, 1'b1, 1'b0);
    send(3'b100, 8'h01, 8'h00, 1'b0); chk_out("xor_par",  8'h01, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_y_hold", 64'(y), 64'h01);

    // Accumulate 01^02^04
    send(3'b111, 8'h01, 8'hAA, 1'b0);
    chk("acc1_novalid", 64'(out_valid), 64'd0);
    send(3'b111, 8'h02, 8'h55, 1'b0);
    chk("acc2_novalid", 64'(out_valid), 64'd0);
    send(3'b111, 8'h04, 8'h00, 1'b1);
    chk_out("acc", 8'h07, 1'b0, 1'b1);
    chk("acc_cleared", 64'(dut.r_acc), 64'h00);
    chk("acc_idle", 64'(dut.r_state), 64'd0);
    @(posedge clk); #1;
    chk("acc_single_result", 64'(out_valid), 64'd0);

    // Backpressure
    out_ready = 1'b0;
    send(3'b000, 8'hF0, 8'hFF, 1'b0);
    chk_out("bp_first", 8'hF0, 1'b0, 1'b0);
    op = 3'b001; a = 8'h01; b = 8'h02; last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk("bp_y_stable", 64'(y), 64'hF0);
      chk("bp_valid_held", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_out("bp_second", 8'h03, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("bp_no_dup", 64'(out_valid), 64'd0);

    // Abort accumulation with a plain op
    send(3'b111, 8'hAA, 8'h00, 1'b0);
    chk("abort_novalid", 64'(out_valid), 64'd0);
    send(3'b000, 8'hFF, 8'h0F, 1'b0);
    chk_out("abort_and", 8'h0F, 1'b0, 1'b0);
    chk("abort_acc_zero", 64'(dut.r_acc), 64'h00);
    send(3'b111, 8'h55, 8'h00, 1'b1);
    chk_out("abort_fresh", 8'h55, 1'b0, 1'b0);

    // Reset mid-accumulation, with a beat presented during reset
    send(3'b111, 8'h11, 8'h00, 1'b0);
    rst_n = 1'b0;
    op = 3'b111; a = 8'h33; last = 1'b1; in_valid = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_y", 64'(y), 64'h00);
    chk("mid_rst_zero", 64'(zero), 64'd1);
    chk("mid_rst_par", 64'(par), 64'd0);
    chk("mid_rst_acc", 64'(dut.r_acc), 64'h00);
    chk("mid_rst_state", 64'(dut.r_state), 64'd0);
    rst_n = 1'b1;
    send(3'b111, 8'h22, 8'h00, 1'b1);
    chk_out("post_rst_acc", 8'h22, 1'b0, 1'b0);

    // Full throughput: 16 back-to-back beats
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r_op_q = 3'($urandom_range(6, 0));
      a_q    = 8'($urandom);
      b_q    = 8'($urandom);
      exp_y  = ref_op(r_op_q, a_q, b_q);
      op = r_op_q; a = a_q; b = b_q; last = 1'($urandom); in_valid = 1'b1;
      #1;
      chk("tp_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      chk("tp_valid", 64'(out_valid), 64'd1);
      chk("tp_y", 64'(y), 64'(exp_y));
      chk("tp_zero", 64'(zero), 64'(exp_y == 8'h00));
      chk("tp_par", 64'(par), 64'(^exp_y));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("tp_drain", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
